router_input_fifo: RTL and testbench
====================================

# router_input_fifo

Per-input-port flit buffer of the router, sitting directly upstream of the LBDR routing stage on the same input port. It accepts flits from the neighbouring router or the local network interface under credit-based flow control and stores them in a circular buffer. It presents the head flit first-word-fall-through, together with the `empty`, `flit_id` and `dst_addr` signals that LBDR consumes. It pops a flit when the output allocator grants this port, and returns one credit upstream per pop.

## Interface
- `DATA_WIDTH`, 32: flit width in bits.
- `DEPTH`, 4: buffer depth in flits; power of two, ≥2.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-low reset.
- `valid_in` input 1: upstream presents a flit on `rx` this cycle.
- `rx` input DATA_WIDTH: incoming flit.
- `read_en` input 5: grant one-hot {N,E,W,S,L} from the output allocators; any bit set requests a pop.
- `data_out` output DATA_WIDTH: head flit, combinational from storage.
- `flit_id` output 3: `data_out[31:29]`.
- `dst_addr` output 4: `data_out[28:25]`.
- `empty` output 1: no flit stored.
- `full` output 1: DEPTH flits stored.
- `credit_out` output 1: one-cycle pulse per popped flit, returned upstream.
- `overflow` output 1: sticky error, set by a write that was dropped.

## Operation
- Storage: DEPTH×DATA_WIDTH array, `wr_ptr` and `rd_ptr` of width log2(DEPTH), and `count` of width log2(DEPTH)+1.
- Pointers wrap modulo DEPTH with no special case.
- `push = valid_in & (~full | pop)`.
- `pop = |read_en & ~empty`. A read request while empty is ignored: no pointer change and no credit.
- Push writes `rx` to `mem[wr_ptr]` and increments `wr_ptr`. Pop increments `rd_ptr`.
- `count` changes as follows:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged
- Full with simultaneous pop and push: the write is accepted and the slot is reused. This is legal under credit flow.
- Full without pop, `valid_in`=1: the flit is dropped, state is unchanged, and `overflow` is set. `overflow` clears only on reset.
- Empty with simultaneous push and `read_en`: the pop is not performed. The new flit appears at the head next cycle.
- `empty = (count==0)` and `full = (count==DEPTH)`, both combinational from registers.
- `read_en` with more than one bit set counts as a single pop. This is an allocator error and is not flagged.
- Flit-type agnostic: HEADER, PAYLOAD and TAIL are buffered identically. Packet ordering is preserved by FIFO order.

## Timing
- Reset (`rst`=0 at an edge) sets:
  - pointers and `count` to 0
  - every memory word to 0
  - `credit_out`=0 and `overflow`=0
- Reset outputs are therefore `empty`=1, `full`=0, and `data_out`/`flit_id`/`dst_addr`=0.
- Reset overrides any simultaneous push or pop.
- Write-to-visible latency is 1 cycle. A flit pushed at edge k drives `data_out` and lowers `empty` after edge k, so LBDR can sample it at edge k+1.
- A pop at edge k advances `data_out` to the next flit after edge k.
- `credit_out` is registered: high for exactly the cycle after each popped edge. It is independent of push.
- Throughput is one push and one pop per cycle sustained, with no bubbles.

## Structure
- Shared package `router_pkg` holds:
  - `FLIT_ID_HI`=31, `FLIT_ID_LO`=29, `DST_HI`=28, `DST_LO`=25
  - flit-type constants HEADER=3'b001, PAYLOAD=3'b010, TAIL=3'b100, which also replace the `include` macros
  - typedef `flit_t` as `logic [31:0]`
- One module. No sub-module is needed; the storage array is inferred in-line.

## Test plan
- Reset, then idle → `empty`=1, `full`=0, `data_out`=0, `credit_out`=0, `overflow`=0.
- Push HEADER 0x2A00_0000 (`dst_addr`=5), then PAYLOAD 0x4000_0011 and TAIL 0x8000_0022; then `read_en`=5'b00100 for 3 cycles →
  - head order matches the pushes
  - `flit_id` is 001, 010, 100 in turn
  - exactly 3 `credit_out` pulses, each one cycle after its pop
- Push 4 flits → `full`=1. A 5th push with no read → dropped, `overflow`=1 and sticky, count remains 4. A 5th push with a concurrent read → accepted, still full, head advances.
- Push/pop every cycle for 20 cycles from count 2 → pointers wrap, count stays 2, output order is preserved, 20 credits.
- `read_en`=5'b10000 while empty → no credit, pointers unchanged. Push and read at the same edge while empty → flit retained, `empty`=0 next cycle.
- Fill to 3, assert `rst`=0 for one edge mid-stream with `valid_in`=1 → all reset values restored and the incoming flit discarded.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: flit field positions, flit-type codes and the flit type.
package router_pkg;

  localparam int FLIT_ID_HI = 31;
  localparam int FLIT_ID_LO = 29;
  localparam int DST_HI     = 28;
  localparam int DST_LO     = 25;

  localparam logic [2:0] HEADER  = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL    = 3'b100;

  typedef logic [31:0] flit_t;

endpackage

// File: rtl/router_input_fifo_if.sv
// Input-port flit handshake: upstream write side, allocator grant and LBDR-facing head view.
interface router_input_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] rx;
  logic [4:0]            read_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic [2:0]            flit_id;
  logic [3:0]            dst_addr;
  logic                  empty;
  logic                  full;
  logic                  credit_out;
  logic                  overflow;

  modport master (
    output valid_in, rx, read_en,
    input  data_out, flit_id, dst_addr, empty, full, credit_out, overflow
  );

  modport slave (
    input  valid_in, rx, read_en,
    output data_out, flit_id, dst_addr, empty, full, credit_out, overflow
  );
endinterface

// File: rtl/router_input_fifo.sv
// Per-input-port circular flit buffer, first-word-fall-through head, credit return per pop.
module router_input_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic               clk,
  input logic               rst,
  router_input_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  credit_q;
  logic                  overflow_q;

  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [DATA_WIDTH-1:0] head;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  assign pop   = (|bus.read_en) & ~empty;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign push  = bus.valid_in & (~full | pop);
  assign drop  = bus.valid_in & ~push;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.rx;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      credit_q <= pop;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.data_out   = head;
  assign bus.flit_id    = head[FLIT_ID_HI:FLIT_ID_LO];
  assign bus.dst_addr   = head[DST_HI:DST_LO];
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.credit_out = credit_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_router_input_fifo.sv
// Bench for router_input_fifo: directed scenarios plus random traffic against a queue model.
module tb_router_input_fifo;
  import router_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  router_input_fifo_if #(.DATA_WIDTH(DW)) bus ();

  router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  flit_t q[$];
  bit    m_ovf;
  bit    m_credit;
  int    n_checks;
  int    n_fail;

  // Drive one edge and advance the queue model by the buffer's rules.
  task automatic cycle(input bit v, input flit_t d, input logic [4:0] re, input bit r = 1'b1);
    bit pop, push;
    bus.valid_in = v;
    bus.rx       = d;
    bus.read_en  = re;
    rst          = r;
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_ovf    = 1'b0;
      m_credit = 1'b0;
    end else begin
      pop  = (re != 5'b0) && (q.size() > 0);
      push = v && ((q.size() < DEPTH) || pop);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
      if (v && !push) m_ovf = 1'b1;
      m_credit = pop;
    end
    #1;
    bus.valid_in = 1'b0;
    bus.read_en  = 5'b0;
    rst          = 1'b1;
  endtask

  function automatic flit_t rand_flit();
    logic [2:0] t;
    case ($urandom_range(0, 2))
      0:       t = HEADER;
      1:       t = PAYLOAD;
      default: t = TAIL;
    endcase
    return {t, 29'($urandom)};
  endfunction

  function automatic logic [4:0] rand_grant();
    return 5'b1 << $urandom_range(0, 4);
  endfunction

  task automatic test_reset();
    cycle(1'b0, '0, 5'b0, 1'b0);
    cycle(1'b0, '0, 5'b0, 1'b0);
    cycle(1'b0, '0, 5'b0);
    n_checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: empty=%b full=%b expected 1/0", bus.empty, bus.full);
    end
    n_checks++;
    if (bus.data_out !== 32'h0 || bus.flit_id !== 3'h0 || bus.dst_addr !== 4'h0) begin
      n_fail++; $display("FAIL reset_data: data_out=%h expected 0", bus.data_out);
    end
    n_checks++;
    if (bus.credit_out !== 1'b0 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: credit=%b ovf=%b expected 0/0", bus.credit_out, bus.overflow);
    end
  endtask

  task automatic test_packet();
    flit_t      pk[3];
    logic [2:0] ids[3];
    int         credits;
    pk[0] = 32'h2A00_0000; pk[1] = 32'h4000_0011; pk[2] = 32'h8000_0022;
    ids[0] = HEADER; ids[1] = PAYLOAD; ids[2] = TAIL;
    for (int i = 0; i < 3; i++) cycle(1'b1, pk[i], 5'b0);
    n_checks++;
    if (bus.dst_addr !== 4'd5 || bus.empty !== 1'b0) begin
      n_fail++; $display("FAIL pkt_dst: dst_addr=%0d empty=%b expected 5/0", bus.dst_addr, bus.empty);
    end
    credits = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.data_out !== pk[i] || bus.flit_id !== ids[i]) begin
        n_fail++; $display("FAIL pkt_head%0d: data=%h id=%b expected %h/%b", i, bus.data_out, bus.flit_id, pk[i], ids[i]);
      end
      cycle(1'b0, '0, 5'b00100);
      n_checks++;
      if (bus.credit_out !== 1'b1) begin
        n_fail++; $display("FAIL pkt_credit%0d: credit=%b expected 1", i, bus.credit_out);
      end
      if (bus.credit_out === 1'b1) credits++;
    end
    cycle(1'b0, '0, 5'b0);
    if (bus.credit_out === 1'b1) credits++;
    n_checks++;
    if (credits != 3 || bus.empty !== 1'b1) begin
      n_fail++; $display("FAIL pkt_credit_total: credits=%0d empty=%b expected 3/1", credits, bus.empty);
    end
  endtask

  task automatic test_full_overflow();
    flit_t extra;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_flit(), 5'b0);
    n_checks++;
    if (bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_set: full=%b ovf=%b expected 1/0", bus.full, bus.overflow);
    end
    cycle(1'b1, rand_flit(), 5'b0);
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.full !== 1'b1 || bus.data_out !== q[0] || q.size() != DEPTH) begin
      n_fail++; $display("FAIL drop: ovf=%b full=%b head=%h expected 1/1/%h", bus.overflow, bus.full, bus.data_out, q[0]);
    end
    cycle(1'b0, '0, 5'b0);
    n_checks++;
    if (bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: ovf=%b expected 1", bus.overflow);
    end
    extra = rand_flit();
    cycle(1'b1, extra, rand_grant());
    n_checks++;
    if (bus.full !== 1'b1 || bus.data_out !== q[0] || bus.credit_out !== 1'b1) begin
      n_fail++; $display("FAIL full_pushpop: full=%b head=%h credit=%b expected 1/%h/1", bus.full, bus.data_out, bus.credit_out, q[0]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (bus.data_out !== q[0]) begin
        n_fail++; $display("FAIL full_drain%0d: head=%h expected %h", i, bus.data_out, q[0]);
      end
      cycle(1'b0, '0, rand_grant());
    end
    n_checks++;
    if (bus.empty !== 1'b1 || q.size() != 0) begin
      n_fail++; $display("FAIL full_drained: empty=%b expected 1", bus.empty);
    end
  endtask

  task automatic test_streaming();
    int credits = 0;
    cycle(1'b1, rand_flit(), 5'b0);
    cycle(1'b1, rand_flit(), 5'b0);
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (bus.data_out !== q[0]) begin
        n_fail++; $display("FAIL stream_head%0d: head=%h expected %h", i, bus.data_out, q[0]);
      end
      cycle(1'b1, rand_flit(), rand_grant());
      if (bus.credit_out === 1'b1) credits++;
      n_checks++;
      if (bus.empty !== 1'b0 || bus.full !== 1'b0 || q.size() != 2) begin
        n_fail++; $display("FAIL stream_level%0d: empty=%b full=%b expected 0/0", i, bus.empty, bus.full);
      end
    end
    n_checks++;
    if (credits != 20) begin
      n_fail++; $display("FAIL stream_credits: got %0d expected 20", credits);
    end
    while (q.size() > 0) begin
      n_checks++;
      if (bus.data_out !== q[0]) begin
        n_fail++; $display("FAIL stream_tail: head=%h expected %h", bus.data_out, q[0]);
      end
      cycle(1'b0, '0, 5'b00001);
    end
  endtask

  task automatic test_empty_read();
    flit_t f;
    cycle(1'b0, '0, 5'b10000);
    n_checks++;
    if (bus.credit_out !== 1'b0 || bus.empty !== 1'b1) begin
      n_fail++; $display("FAIL empty_read: credit=%b empty=%b expected 0/1", bus.credit_out, bus.empty);
    end
    f = rand_flit();
    cycle(1'b1, f, 5'b10000);
    n_checks++;
    if (bus.empty !== 1'b0 || bus.data_out !== f || bus.credit_out !== 1'b0) begin
      n_fail++; $display("FAIL empty_pushread: empty=%b head=%h credit=%b expected 0/%h/0", bus.empty, bus.data_out, bus.credit_out, f);
    end
    cycle(1'b0, '0, 5'b01000);
    n_checks++;
    if (bus.empty !== 1'b1 || bus.credit_out !== 1'b1) begin
      n_fail++; $display("FAIL empty_pop: empty=%b credit=%b expected 1/1", bus.empty, bus.credit_out);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_flit(), 5'b0);
    cycle(1'b1, rand_flit(), rand_grant(), 1'b0);
    n_checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.credit_out !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ctrl: empty=%b full=%b ovf=%b credit=%b expected 1/0/0/0", bus.empty, bus.full, bus.overflow, bus.credit_out);
    end
    n_checks++;
    if (bus.data_out !== 32'h0 || bus.flit_id !== 3'h0 || bus.dst_addr !== 4'h0) begin
      n_fail++; $display("FAIL midrst_data: data_out=%h expected 0", bus.data_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_flit(),
            ($urandom_range(0, 2) == 0) ? 5'b0 : 5'($urandom_range(1, 31)));
      n_checks++;
      if (bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH) ||
          bus.credit_out !== m_credit || bus.overflow !== m_ovf) begin
        n_fail++; $display("FAIL rand_ctrl%0d: e=%b f=%b c=%b o=%b expected %b/%b/%b/%b", i,
                           bus.empty, bus.full, bus.credit_out, bus.overflow,
                           q.size() == 0, q.size() == DEPTH, m_credit, m_ovf);
      end
      if (q.size() > 0) begin
        n_checks++;
        if (bus.data_out !== q[0]) begin
          n_fail++; $display("FAIL rand_head%0d: head=%h expected %h", i, bus.data_out, q[0]);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.valid_in = 1'b0;
    bus.rx       = '0;
    bus.read_en  = 5'b0;
    test_reset();
    test_packet();
    test_full_overflow();
    test_streaming();
    test_empty_read();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
